// File: rtl/split_accum_recombiner_pkg.sv
// ---------------------------------------------------------------------------
// split_accum_recombiner_pkg : split-point constant and FSM encodings
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package split_accum_recombiner_pkg;

  // Split point shared with the upstream overflow-adjust split stage
  localparam int LSP_WIDTH = 18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMBINE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/split_lane_recombine.sv
// ---------------------------------------------------------------------------
// split_lane_recombine : shift-and-add of guarded MSP/LSP lanes into one sum
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module split_lane_recombine
  import split_accum_recombiner_pkg::*;
#(
  parameter int MSP_ACC_WIDTH = 38,
  parameter int LSP_ACC_WIDTH = 26,
  parameter int RESULT_WIDTH  = 56
) (
  input  logic [MSP_ACC_WIDTH-1:0] msp_acc_i,
  input  logic [LSP_ACC_WIDTH-1:0] lsp_acc_i,
  output logic [RESULT_WIDTH-1:0]  result_o
);

  logic [RESULT_WIDTH-1:0] w_msp_shifted;
  logic [RESULT_WIDTH-1:0] w_lsp_ext;

  // LSP guard bits overlap the shifted MSP lane; the add folds them in
  assign w_msp_shifted = RESULT_WIDTH'({msp_acc_i, {LSP_WIDTH{1'b0}}});
  assign w_lsp_ext     = RESULT_WIDTH'(lsp_acc_i);
  assign result_o      = w_msp_shifted + w_lsp_ext;

endmodule

`default_nettype wire

// File: rtl/split_accum_recombiner.sv
// ---------------------------------------------------------------------------
// split_accum_recombiner : accumulates MSP/LSP split pairs per group and
// presents the exact recombined wide sum on a valid/ready output. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module split_accum_recombiner
  import split_accum_recombiner_pkg::*;
#(
  parameter int ACCUM_WIDTH  = 48,
  parameter int MAX_TERMS    = 256,
  parameter int CNT_WIDTH    = 8,
  parameter int RESULT_WIDTH = ACCUM_WIDTH + CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [ACCUM_WIDTH-1:0]  in_msp_i,
  input  logic [ACCUM_WIDTH-1:0]  in_lsp_i,
  input  logic                    in_last_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [RESULT_WIDTH-1:0] out_result_o,
  output logic [CNT_WIDTH:0]      out_count_o,
  output logic                    out_ovf_o,
  output logic                    out_fmt_err_o
);

  localparam int MSP_WIDTH     = ACCUM_WIDTH - LSP_WIDTH;
  localparam int LSP_ACC_WIDTH = LSP_WIDTH + CNT_WIDTH;
  localparam int MSP_ACC_WIDTH = MSP_WIDTH + CNT_WIDTH;
  localparam logic [CNT_WIDTH:0] CNT_ONE = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH:0] CNT_MAX = (CNT_WIDTH+1)'(MAX_TERMS);

  state_t                   state_q, state_d;
  logic [LSP_ACC_WIDTH-1:0] lsp_acc_q, lsp_acc_d;
  logic [MSP_ACC_WIDTH-1:0] msp_acc_q, msp_acc_d;
  logic [CNT_WIDTH:0]       cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     fmt_err_q, fmt_err_d;
  logic [RESULT_WIDTH-1:0]  result_q, result_d;

  logic [LSP_ACC_WIDTH-1:0] w_lsp_ext;
  logic [MSP_ACC_WIDTH-1:0] w_msp_ext;
  logic                     w_fmt_err;
  logic [RESULT_WIDTH-1:0]  w_sum;

  // Out-of-field bits are dropped from the sum and only flagged
  assign w_lsp_ext = {{CNT_WIDTH{1'b0}}, in_lsp_i[LSP_WIDTH-1:0]};
  assign w_msp_ext = {{CNT_WIDTH{1'b0}}, in_msp_i[MSP_WIDTH-1:0]};
  assign w_fmt_err = (|in_lsp_i[ACCUM_WIDTH-1:LSP_WIDTH]) |
                     (|in_msp_i[ACCUM_WIDTH-1:MSP_WIDTH]);

  split_lane_recombine #(
    .MSP_ACC_WIDTH (MSP_ACC_WIDTH),
    .LSP_ACC_WIDTH (LSP_ACC_WIDTH),
    .RESULT_WIDTH  (RESULT_WIDTH)
  ) u_recombine (
    .msp_acc_i (msp_acc_q),
    .lsp_acc_i (lsp_acc_q),
    .result_o  (w_sum)
  );

  always_comb begin
    state_d     = state_q;
    lsp_acc_d   = lsp_acc_q;
    msp_acc_d   = msp_acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    fmt_err_d   = fmt_err_q;
    result_d    = result_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          lsp_acc_d = w_lsp_ext;
          msp_acc_d = w_msp_ext;
          cnt_d     = CNT_ONE;
          ovf_d     = 1'b0;
          fmt_err_d = w_fmt_err;
          state_d   = in_last_i ? ST_COMBINE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          lsp_acc_d = lsp_acc_q + w_lsp_ext;
          msp_acc_d = msp_acc_q + w_msp_ext;
          fmt_err_d = fmt_err_q | w_fmt_err;
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (in_last_i) begin
            state_d = ST_COMBINE;
          end
        end
      end
      ST_COMBINE: begin
        result_d = w_sum;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          lsp_acc_d = '0;
          msp_acc_d = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          fmt_err_d = 1'b0;
          result_d  = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lsp_acc_q <= '0;
      msp_acc_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      fmt_err_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      lsp_acc_q <= lsp_acc_d;
      msp_acc_q <= msp_acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      fmt_err_q <= fmt_err_d;
      result_q  <= result_d;
    end
  end

  assign out_result_o  = result_q;
  assign out_count_o   = cnt_q;
  assign out_ovf_o     = ovf_q;
  assign out_fmt_err_o = fmt_err_q;

endmodule

`default_nettype wire
